// File: rtl/hazard_scheduler_pkg.sv
// Shared definitions for the hazard scheduler: board size, phase encodings
// and the Galois LFSR step used to draw fire/gold patterns.
package hazard_scheduler_pkg;

  localparam int          CELLS       = 9;
  localparam logic [15:0] LFSR_MASK   = 16'hB400;
  localparam logic [8:0]  CENTRE_CELL = 9'h010;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_PREVIEW = 3'd1,
    PH_ACTIVE  = 3'd2,
    PH_RESOLVE = 3'd3,
    PH_DONE    = 3'd4
  } phase_e;

  // Right-shifting Galois step; the mask is folded in when a one falls out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/hazard_lfsr.sv
// Pattern source: 16-bit Galois LFSR plus the combinational fire/gold draw
// taken from its current state.
module hazard_lfsr
  import hazard_scheduler_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_i,
  output logic [CELLS-1:0] fire_o,
  output logic [CELLS-1:0] gold_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic [3:0]  gidx_s;

  always_comb begin
    if (step_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // An all-clear draw would be a free round, so it becomes the centre cell.
  always_comb begin
    fire_o = '0;
    gold_o = '0;
    gidx_s = lfsr_q[12:9] % 4'd9;
    if (lfsr_q[8:0] == 9'd0) begin
      fire_o = CENTRE_CELL;
    end else begin
      fire_o = lfsr_q[8:0];
    end
    if (!fire_o[gidx_s]) begin
      gold_o[gidx_s] = 1'b1;
    end else begin
      gold_o = '0;
    end
  end

endmodule

// File: rtl/hazard_scheduler.sv
// Round sequencer: preview -> active -> resolve per round, judges the box
// switches and emits one-cycle hit/miss/gold strobes for score/life logic.
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int          PREVIEW_TICKS = 2,
  parameter int          ACTIVE_TICKS  = 3,
  parameter int          MAX_ROUNDS    = 15,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             tick_i,
  input  logic [CELLS-1:0] box_i,
  input  logic             super_i,
  output logic [CELLS-1:0] next_fire_pattern_o,
  output logic [CELLS-1:0] fire_state_o,
  output logic [CELLS-1:0] gold_state_o,
  output logic [2:0]       phase_o,
  output logic [3:0]       round_o,
  output logic             hit_pulse_o,
  output logic             miss_pulse_o,
  output logic             gold_pulse_o,
  output logic             rounds_done_o
);

  localparam logic [3:0] PREV_T = 4'(PREVIEW_TICKS);
  localparam logic [3:0] ACT_T  = 4'(ACTIVE_TICKS);
  localparam logic [3:0] MAX_R  = 4'(MAX_ROUNDS);

  phase_e           phase_q, phase_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       round_q, round_d;
  logic [CELLS-1:0] next_q, next_d;
  logic [CELLS-1:0] fire_q, fire_d;
  logic [CELLS-1:0] gold_q, gold_d;
  logic [CELLS-1:0] pend_q, pend_d;
  logic             hit_q, hit_d;
  logic             miss_q, miss_d;
  logic             gpul_q, gpul_d;
  logic             done_q, done_d;

  logic [CELLS-1:0] draw_fire_s;
  logic [CELLS-1:0] draw_gold_s;
  logic [3:0]       cnt_inc_s;
  logic             miss_s;
  logic             last_round_s;

  hazard_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .step_i (enable_i),
    .fire_o (draw_fire_s),
    .gold_o (draw_gold_s)
  );

  always_comb begin
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    round_d      = round_q;
    next_d       = next_q;
    fire_d       = fire_q;
    gold_d       = gold_q;
    pend_d       = pend_q;
    done_d       = done_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    gpul_d       = 1'b0;
    cnt_inc_s    = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    miss_s       = (|(fire_q & ~box_i)) & ~super_i;
    last_round_s = ((round_q + 4'd1) == MAX_R);

    // Dropping enable overrides everything, including a coincident tick.
    if (!enable_i) begin
      phase_d = PH_IDLE;
      next_d  = '0;
      fire_d  = '0;
      gold_d  = '0;
      pend_d  = '0;
      cnt_d   = 4'd0;
      done_d  = 1'b0;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          phase_d = PH_PREVIEW;
          next_d  = draw_fire_s;
          pend_d  = draw_gold_s;
          fire_d  = '0;
          gold_d  = '0;
          round_d = 4'd0;
          cnt_d   = 4'd0;
          done_d  = 1'b0;
        end
        PH_PREVIEW: begin
          if (tick_i && (cnt_inc_s >= PREV_T)) begin
            phase_d = PH_ACTIVE;
            fire_d  = next_q;
            gold_d  = pend_q;
            next_d  = '0;
            cnt_d   = 4'd0;
          end else if (tick_i) begin
            cnt_d = cnt_inc_s;
          end else begin
            cnt_d = cnt_q;
          end
        end
        PH_ACTIVE: begin
          if (tick_i && (cnt_inc_s >= ACT_T)) begin
            phase_d = PH_RESOLVE;
            cnt_d   = 4'd0;
          end else if (tick_i) begin
            cnt_d = cnt_inc_s;
          end else begin
            cnt_d = cnt_q;
          end
        end
        PH_RESOLVE: begin
          // Strobes are registered so they appear the cycle after judging.
          hit_d   = ~miss_s;
          miss_d  = miss_s;
          gpul_d  = |(gold_q & ~box_i);
          round_d = round_q + 4'd1;
          fire_d  = '0;
          gold_d  = '0;
          cnt_d   = 4'd0;
          if (last_round_s) begin
            phase_d = PH_DONE;
            done_d  = 1'b1;
            next_d  = '0;
            pend_d  = '0;
          end else begin
            phase_d = PH_PREVIEW;
            next_d  = draw_fire_s;
            pend_d  = draw_gold_s;
          end
        end
        PH_DONE: begin
          done_d = 1'b1;
        end
        default: begin
          phase_d = PH_IDLE;
          next_d  = '0;
          fire_d  = '0;
          gold_d  = '0;
          pend_d  = '0;
          cnt_d   = 4'd0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      cnt_q   <= 4'd0;
      round_q <= 4'd0;
      next_q  <= '0;
      fire_q  <= '0;
      gold_q  <= '0;
      pend_q  <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      gpul_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      next_q  <= next_d;
      fire_q  <= fire_d;
      gold_q  <= gold_d;
      pend_q  <= pend_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      gpul_q  <= gpul_d;
      done_q  <= done_d;
    end
  end

  assign next_fire_pattern_o = next_q;
  assign fire_state_o        = fire_q;
  assign gold_state_o        = gold_q;
  assign phase_o             = phase_q;
  assign round_o             = round_q;
  assign hit_pulse_o         = hit_q;
  assign miss_pulse_o        = miss_q;
  assign gold_pulse_o        = gpul_q;
  assign rounds_done_o       = done_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench: directed round sequences followed by random stimulus,
// every cycle compared against a behavioural game model.
module tb_hazard_scheduler;

  localparam int PT = 2;
  localparam int AT = 3;
  localparam int MR = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       tick = 1'b0;
  logic       sup = 1'b0;
  logic [8:0] box = 9'd0;

  logic [8:0] next_fire_pattern, fire_state, gold_state;
  logic [2:0] phase;
  logic [3:0] round;
  logic       hit_pulse, miss_pulse, gold_pulse, rounds_done;

  int vectors = 0;
  int errors  = 0;

  // Model state: phase as 0..4, tick count, patterns, strobes, lfsr.
  int          m_ph, m_cnt, m_round;
  logic [8:0]  m_nfp, m_fs, m_gs, m_pend;
  logic        m_hit, m_miss, m_gp, m_rd;
  logic [15:0] m_lfsr;

  hazard_scheduler dut (
    .clk                 (clk),
    .rst                 (rst),
    .enable_i            (en),
    .tick_i              (tick),
    .box_i               (box),
    .super_i             (sup),
    .next_fire_pattern_o (next_fire_pattern),
    .fire_state_o        (fire_state),
    .gold_state_o        (gold_state),
    .phase_o             (phase),
    .round_o             (round),
    .hit_pulse_o         (hit_pulse),
    .miss_pulse_o        (miss_pulse),
    .gold_pulse_o        (gold_pulse),
    .rounds_done_o       (rounds_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_round = 0;
    m_nfp = 9'd0; m_fs = 9'd0; m_gs = 9'd0; m_pend = 9'd0;
    m_hit = 1'b0; m_miss = 1'b0; m_gp = 1'b0; m_rd = 1'b0;
    m_lfsr = 16'hACE1;
  endtask

  function automatic void draw(input logic [15:0] l, output logic [8:0] f, output logic [8:0] g);
    int gi;
    f = l[8:0];
    if (f == 9'd0) f = 9'h010;
    gi = int'(l[12:9]) % 9;
    g = 9'd0;
    if (f[gi] == 1'b0) g[gi] = 1'b1;
  endfunction

  task automatic model_step(input logic e, input logic t, input logic [8:0] b, input logic s);
    logic [8:0] df, dg;
    draw(m_lfsr, df, dg);
    m_hit = 1'b0; m_miss = 1'b0; m_gp = 1'b0;
    if (!e) begin
      m_ph = 0; m_nfp = 9'd0; m_fs = 9'd0; m_gs = 9'd0; m_pend = 9'd0;
      m_cnt = 0; m_rd = 1'b0;
    end else begin
      case (m_ph)
        0: begin m_ph = 1; m_nfp = df; m_pend = dg; m_round = 0; m_cnt = 0; end
        1: if (t) begin
             m_cnt++;
             if (m_cnt >= PT) begin
               m_ph = 2; m_fs = m_nfp; m_gs = m_pend; m_nfp = 9'd0; m_cnt = 0;
             end
           end
        2: if (t) begin
             m_cnt++;
             if (m_cnt >= AT) begin m_ph = 3; m_cnt = 0; end
           end
        3: begin
             m_miss = ((m_fs & ~b) != 9'd0) && !s;
             m_hit  = !m_miss;
             m_gp   = ((m_gs & ~b) != 9'd0);
             m_round++;
             m_fs = 9'd0; m_gs = 9'd0; m_cnt = 0;
             if (m_round == MR) begin
               m_ph = 4; m_rd = 1'b1; m_nfp = 9'd0; m_pend = 9'd0;
             end else begin
               m_ph = 1; m_nfp = df; m_pend = dg;
             end
           end
        default: ;
      endcase
      if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
      else           m_lfsr = m_lfsr >> 1;
    end
  endtask

  task automatic compare_all();
    check_eq("phase", 32'(phase), 32'(m_ph));
    check_eq("next_fire", 32'(next_fire_pattern), 32'(m_nfp));
    check_eq("fire_state", 32'(fire_state), 32'(m_fs));
    check_eq("gold_state", 32'(gold_state), 32'(m_gs));
    check_eq("round", 32'(round), 32'(m_round));
    check_eq("pulses", 32'({hit_pulse, miss_pulse, gold_pulse}), 32'({m_hit, m_miss, m_gp}));
    check_eq("rounds_done", 32'(rounds_done), 32'(m_rd));
  endtask

  task automatic cycle(input logic e, input logic t, input logic [8:0] b, input logic s);
    @(negedge clk);
    rst = 1'b0; en = e; tick = t; box = b; sup = s;
    model_step(e, t, b, s);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_async_reset();
    @(negedge clk);
    en = 1'b0; tick = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n, input logic [8:0] b, input logic s);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b1, b, s);
  endtask

  initial begin
    logic       e, t, s;
    logic [8:0] b;
    int         guard;

    model_reset();
    #1 rst = 1'b1;
    #2 compare_all();
    cycle(1'b0, 1'b0, 9'd0, 1'b0);

    // Start: one cycle to PREVIEW, preview drawn from the seed state.
    cycle(1'b1, 1'b0, 9'd0, 1'b0);
    check_eq("idle_to_preview", 32'(phase), 32'd1);
    check_eq("first_preview", 32'(next_fire_pattern), 32'h0E1);
    check_eq("first_fire_clear", 32'(fire_state), 32'd0);
    ticks(2, 9'd0, 1'b0);
    check_eq("preview_to_active", 32'(phase), 32'd2);
    check_eq("active_fire", 32'(fire_state), 32'h0E1);
    ticks(3, 9'd0, 1'b0);
    check_eq("active_to_resolve", 32'(phase), 32'd3);
    cycle(1'b1, 1'b0, 9'h1FF, 1'b0);
    check_eq("covered_pulses", 32'({hit_pulse, miss_pulse, gold_pulse}), 32'b100);
    check_eq("covered_round", 32'(round), 32'd1);
    check_eq("resolve_one_cycle", 32'(phase), 32'd1);
    cycle(1'b1, 1'b0, 9'h1FF, 1'b0);
    check_eq("pulse_one_cycle", 32'({hit_pulse, miss_pulse, gold_pulse}), 32'b000);

    // Open board: miss (gold per model), then the same under super.
    ticks(5, 9'd0, 1'b0);
    cycle(1'b1, 1'b0, 9'd0, 1'b0);
    check_eq("open_miss", 32'(miss_pulse), 32'd1);
    ticks(5, 9'd0, 1'b1);
    cycle(1'b1, 1'b0, 9'd0, 1'b1);
    check_eq("super_hit", 32'({hit_pulse, miss_pulse}), 32'b10);

    // Enable falls in ACTIVE together with a tick.
    ticks(2, 9'd0, 1'b0);
    check_eq("drop_setup", 32'(phase), 32'd2);
    cycle(1'b0, 1'b1, 9'd0, 1'b0);
    check_eq("drop_phase", 32'(phase), 32'd0);
    check_eq("drop_patterns", 32'({next_fire_pattern, fire_state, gold_state}), 32'd0);
    check_eq("drop_pulses", 32'({hit_pulse, miss_pulse, gold_pulse}), 32'd0);

    // Async reset mid-PREVIEW brings the LFSR back to its seed.
    cycle(1'b1, 1'b0, 9'd0, 1'b0);
    check_eq("rst_setup", 32'(phase), 32'd1);
    do_async_reset();
    cycle(1'b1, 1'b0, 9'd0, 1'b0);
    check_eq("lfsr_reseed", 32'(next_fire_pattern), 32'h0E1);

    // Run a full game with continuous ticks up to DONE.
    guard = 0;
    while (m_ph != 4 && guard < 400) begin
      cycle(1'b1, 1'b1, 9'($urandom), 1'b0);
      guard++;
    end
    check_eq("reach_done", 32'(rounds_done), 32'd1);
    check_eq("done_round", 32'(round), 32'(MR));
    cycle(1'b0, 1'b0, 9'd0, 1'b0);
    check_eq("done_exit", 32'({phase, rounds_done}), 32'd0);

    for (int i = 0; i < 5000; i++) begin
      if (($urandom % 1500) == 0) begin
        do_async_reset();
      end else begin
        if (en) e = (($urandom % ((m_ph == 4) ? 6 : 300)) != 0);
        else    e = (($urandom % 3) == 0);
        t = (($urandom % 5) < 3);
        s = (($urandom % 5) == 0);
        case ($urandom % 4)
          0:       b = 9'h1FF;
          1:       b = 9'h000;
          2:       b = 9'($urandom);
          default: b = m_fs;
        endcase
        cycle(e, t, b, s);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
